fetch_sequencer: RTL

Instruction-fetch controller that sequences the combinational instruction ROM (word-indexed, base 0x0000_3000, 4096 words). It owns the PC register and drives the ROM address every cycle. Each returned word and its PC are captured into a small prefetch buffer, which hands them to decode over a valid/ready handshake. It also handles branch/jump redirects, halt requests and out-of-range or misaligned fetch faults.

---
 rtl/fetch_sequencer_pkg.sv | 32 +++
 rtl/fetch_buffer.sv | 74 +++++++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch constants, FSM encoding, buffer entry layout and the legal-PC check.
package fetch_sequencer_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_3000;
    localparam int unsigned DEF_IM_WORDS  = 4096;
    localparam int unsigned DEF_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] words);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] p;
        lo = {1'b0, base};
        hi = lo + ({1'b0, words} << 2);
        p  = {1'b0, pc};
        return (pc[1:0] == 2'b00) && (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular prefetch FIFO of {pc, instr}; head is visible the cycle after the push.
// Flush wins over push/pop; a push while full is only accepted together with a pop.
module fetch_buffer
    import fetch_sequencer_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_BUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_dat;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_dat = mem_q[head_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads the combinational ROM, feeds decode.
// ROM word enters the buffer at the fetch edge (head one cycle later); stalls when the buffer is full.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned IM_WORDS  = DEF_IM_WORDS,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [1:0]  state_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;

    fetch_entry_t     head_dat;
    fetch_entry_t     push_dat;
    logic             buf_full;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    logic             pop;
    logic             pc_ok;
    logic             try_fetch;
    logic             push;

    assign pop       = if_valid && if_ready;
    assign pc_ok     = pc_legal(pc_q, BASE_ADDR, IM_WORDS);
    // A fetch "would occur" only when every gate except PC legality is open.
    assign try_fetch = (state_q == ST_RUN) && !redirect_valid && !halt_req && (!buf_full || pop);
    assign push      = try_fetch && pc_ok;
    assign push_dat  = '{pc: pc_q, instr: im_instr};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            fault_d    = 1'b0;
            fault_pc_d = '0;
            state_d    = (state_q == ST_HALT && halt_req) ? ST_HALT : ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (try_fetch && !pc_ok) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else if (push) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_HALT: begin
                    if (!halt_req) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            pc_q       <= BASE_ADDR;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    assign im_pc       = pc_q;
    assign if_valid    = !buf_empty;
    assign if_instr    = head_dat.instr;
    assign if_pc       = head_dat.pc;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign state_o     = state_q;

    a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
        buf_count <= CNT_W'(BUF_DEPTH));

endmodule
